// File: rtl/vm_pkg.sv
// vm_pkg: shared change codes, denominations, coin-count decode and dispenser states
// Shared by the vending-side blocks and the change dispenser.
//   CHG_*    3-bit change codes from the vending FSM
//   DENOM_*  coin face values
//   state_t  dispenser FSM state
//   decode() expands a change code into Rs10/Rs5 coin counts plus a legality flag
package vm_pkg;
  localparam logic [2:0] CHG_NONE  = 3'b000;
  localparam logic [2:0] CHG_5     = 3'b001;
  localparam logic [2:0] CHG_10    = 3'b010;
  localparam logic [2:0] CHG_5_10  = 3'b011;
  localparam logic [2:0] CHG_10_10 = 3'b100;
  localparam int DENOM_5  = 5;
  localparam int DENOM_10 = 10;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_WAIT_ACK,
    S_GAP,
    S_DONE
  } state_t;
  typedef struct packed {
    logic       legal;
    logic [1:0] n10;
    logic       n5;
  } coins_t;
  function automatic coins_t decode(input logic [2:0] c);
    coins_t r;
    r.legal = c <= CHG_10_10;
    r.n10   = (c == CHG_10 || c == CHG_5_10) ? 2'd1 : c == CHG_10_10 ? 2'd2 : 2'd0;
    r.n5    = c == CHG_5 || c == CHG_5_10;
    return r;
  endfunction
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request and hopper handshake between vending FSM, dispenser and hopper
// Signals:
//   change[2:0], change_valid, change_ready  request from the vending FSM
//   fire5, fire10, hopper_ack                eject pulses and hopper acknowledge
//   busy, done, fault                        request status
// Modports: slave = dispenser side, master = environment (vending FSM + hopper) side.
interface change_dispenser_if;
  logic [2:0] change;
  logic       change_valid;
  logic       change_ready;
  logic       fire5;
  logic       fire10;
  logic       hopper_ack;
  logic       busy;
  logic       done;
  logic       fault;
  modport slave (
    input  change, change_valid, hopper_ack,
    output change_ready, fire5, fire10, busy, done, fault
  );
  modport master (
    output change, change_valid, hopper_ack,
    input  change_ready, fire5, fire10, busy, done, fault
  );
endinterface

// File: rtl/coin_stock_counter.sv
// coin_stock_counter: per-denomination coin stock with saturating refill and ack decrement
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset (loads STOCK_INIT)
//   refill            add refill_cnt this cycle
//   dec               one coin left the hopper this cycle
//   refill_cnt        refill amount
//   stock             registered stock, saturates at all-ones and never wraps
module coin_stock_counter #(
  parameter int STOCK_W    = 8,
  parameter int STOCK_INIT = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               refill,
  input  logic               dec,
  input  logic [STOCK_W-1:0] refill_cnt,
  output logic [STOCK_W-1:0] stock
);
  logic [STOCK_W:0] sum, nxt;
  // One extra bit lets refill and decrement combine before saturating, so a
  // same-cycle refill and ack yields old + refill_cnt - 1.
  always_comb begin
    sum = {1'b0, stock} + (refill ? {1'b0, refill_cnt} : '0);
    nxt = (dec && sum != '0) ? sum - (STOCK_W+1)'(1) : sum;
  end
  always_ff @(posedge clock)
    if (reset) stock <= STOCK_W'(STOCK_INIT);
    else stock <= nxt[STOCK_W] ? '1 : nxt[STOCK_W-1:0];
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: expands a change code into Rs10/Rs5 coin ejects and tracks coin stock
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   bus (slave)           change/change_valid/change_ready request, fire5/fire10/hopper_ack
//                         hopper handshake, busy/done/fault status
//   refill5, refill10     one-cycle pulses adding refill_cnt to the matching stock
//   refill_cnt            refill amount
//   stock5, stock10       registered stock per denomination
// Build option: define CHG_TIMEOUT_EN to abort a request after ACK_TIMEOUT cycles in
// WAIT_ACK without hopper_ack; otherwise WAIT_ACK waits indefinitely.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int STOCK_W     = 8,
  parameter int STOCK_INIT  = 20,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  change_dispenser_if.slave  bus,
  input  logic               refill5,
  input  logic               refill10,
  input  logic [STOCK_W-1:0] refill_cnt,
  output logic [STOCK_W-1:0] stock5,
  output logic [STOCK_W-1:0] stock10
);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  if (GAP_CYCLES < 1 || ACK_TIMEOUT < 1 || STOCK_INIT > 2**STOCK_W - 1) begin : g_bad_params
    $error("change_dispenser: illegal parameter combination");
  end
  state_t           state;
  logic [2:0]       code;
  logic [1:0]       n10;
  logic             n5;
  logic             cur10;
  logic [GAP_W-1:0] gap_cnt;
  logic             fire5, fire10, done, fault;
  logic             ack_ok, last;
  coins_t           need;
`ifdef CHG_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
`endif
  assign need             = decode(code);
  assign ack_ok           = state == S_WAIT_ACK && bus.hopper_ack;
  assign last             = (n10 + {1'b0, n5}) == 2'd1;
  assign bus.change_ready = state == S_IDLE;
  assign bus.busy         = state != S_IDLE;
  assign bus.fire5        = fire5;
  assign bus.fire10       = fire10;
  assign bus.done         = done;
  assign bus.fault        = fault;
  coin_stock_counter #(.STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)) u_stock5 (
    .clock(clock), .reset(reset), .refill(refill5), .dec(ack_ok && !cur10),
    .refill_cnt(refill_cnt), .stock(stock5)
  );
  coin_stock_counter #(.STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)) u_stock10 (
    .clock(clock), .reset(reset), .refill(refill10), .dec(ack_ok && cur10),
    .refill_cnt(refill_cnt), .stock(stock10)
  );
  // Pulse outputs are set on the transition into the state that owns them, so
  // they are registered and high for exactly that state's single cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      code    <= CHG_NONE;
      n10     <= 2'd0;
      n5      <= 1'b0;
      cur10   <= 1'b0;
      gap_cnt <= '0;
      fire5   <= 1'b0;
      fire10  <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
`ifdef CHG_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      fire5  <= 1'b0;
      fire10 <= 1'b0;
      done   <= 1'b0;
      fault  <= 1'b0;
      case (state)
        S_IDLE: if (bus.change_valid) begin
          code  <= bus.change;
          state <= S_LOAD;
        end
        S_LOAD:
          if (!need.legal || stock10 < STOCK_W'(need.n10) || stock5 < STOCK_W'(need.n5)) begin
            fault <= 1'b1;
            state <= S_IDLE;
          end else if (need.n10 == 2'd0 && !need.n5) state <= S_IDLE;
          else begin
            n10    <= need.n10;
            n5     <= need.n5;
            cur10  <= need.n10 != 2'd0;
            fire10 <= need.n10 != 2'd0;
            fire5  <= need.n10 == 2'd0;
            state  <= S_FIRE;
          end
        S_FIRE: begin
          state  <= S_WAIT_ACK;
`ifdef CHG_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        S_WAIT_ACK:
          if (bus.hopper_ack) begin
            if (cur10) n10 <= n10 - 2'd1;
            else n5 <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end
`ifdef CHG_TIMEOUT_EN
          else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
            fault <= 1'b1;
            state <= S_IDLE;
          end else to_cnt <= to_cnt + TO_W'(1);
`endif
        // Rs10 coins drain first, so the next coin is Rs10 while any remain.
        S_GAP:
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            cur10  <= n10 != 2'd0;
            fire10 <= n10 != 2'd0;
            fire5  <= n10 == 2'd0;
            state  <= S_FIRE;
          end else gap_cnt <= gap_cnt + GAP_W'(1);
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench for change_dispenser (fire/done/fault event order, stock, timing)
module tb_change_dispenser;
  import vm_pkg::*;
  localparam int EV_DONE  = 1;
  localparam int EV_FAULT = 2;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       refill5 = 1'b0;
  logic       refill10 = 1'b0;
  logic [7:0] refill_cnt = 8'd0;
  logic [7:0] stock5, stock10;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int exp_q[$];
  int fire_cyc[$];
  int m_obs, m_exp;
  change_dispenser_if bus();
  change_dispenser dut (
    .clock(clock), .reset(reset), .bus(bus),
    .refill5(refill5), .refill10(refill10), .refill_cnt(refill_cnt),
    .stock5(stock5), .stock10(stock10)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  // Every output event is popped against the order predicted when stimulus was sent.
  always @(negedge clock)
    if (!reset && (bus.fire5 || bus.fire10 || bus.done || bus.fault)) begin
      m_obs = (int'(bus.fire5) + int'(bus.fire10) + int'(bus.done) + int'(bus.fault) > 1) ? -1 :
              bus.fire10 ? DENOM_10 : bus.fire5 ? DENOM_5 : bus.done ? EV_DONE : EV_FAULT;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected event %0d at cycle %0d, nothing expected", m_obs, cyc);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_obs !== m_exp) begin
          errors++;
          $display("FAIL scoreboard: event %0d at cycle %0d, expected %0d", m_obs, cyc, m_exp);
        end
      end
    end
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.hopper_ack = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask
  task automatic send(input logic [2:0] c);
    @(negedge clock);
    bus.change = c;
    bus.change_valid = 1'b1;
    acc_cyc = cyc;
    @(negedge clock);
    bus.change_valid = 1'b0;
  endtask
  // Hopper model: acks d cycles after each fire (d=0 never acks); stops on done/fault.
  task automatic serve(input int d, input bit refill_on_ack);
    int cnt = 0;
    bit fin = 0;
    fire_cyc.delete();
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clock);
      bus.hopper_ack = 1'b0;
      refill10 = 1'b0;
      if (bus.done || bus.fault) begin
        fin = 1;
        done_cyc = cyc;
      end else if (bus.fire10 || bus.fire5) begin
        fire_cyc.push_back(cyc);
        cnt = d;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.hopper_ack = 1'b1;
          if (refill_on_ack) begin
            refill10 = 1'b1;
            refill_cnt = 8'd5;
          end
        end
      end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL serve_timeout: no done/fault within 200 cycles");
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (stock5 !== 8'd20 || stock10 !== 8'd20) begin
      errors++;
      $display("FAIL reset_stock: stock5=%0d stock10=%0d, expected 20 20", stock5, stock10);
    end
    checks++;
    if ({bus.change_ready, bus.busy, bus.fire5, bus.fire10, bus.done, bus.fault} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs: ready/busy/f5/f10/done/fault=%b, expected 100000",
               {bus.change_ready, bus.busy, bus.fire5, bus.fire10, bus.done, bus.fault});
    end
  endtask
  task automatic test_single10();
    do_reset();
    exp_q.push_back(DENOM_10);
    exp_q.push_back(EV_DONE);
    send(CHG_10);
    checks++;
    if (bus.busy !== 1'b1 || bus.change_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_load: busy=%b ready=%b, expected 1 0", bus.busy, bus.change_ready);
    end
    serve(2, 0);
    checks++;
    if (done_cyc - acc_cyc !== 5) begin
      errors++;
      $display("FAIL single10_latency: %0d cycles, expected 5", done_cyc - acc_cyc);
    end
    checks++;
    if (stock10 !== 8'd19 || stock5 !== 8'd20) begin
      errors++;
      $display("FAIL single10_stock: stock10=%0d stock5=%0d, expected 19 20", stock10, stock5);
    end
  endtask
  task automatic test_latency5();
    do_reset();
    exp_q.push_back(DENOM_5);
    exp_q.push_back(EV_DONE);
    send(CHG_5);
    serve(1, 0);
    checks++;
    if (done_cyc - acc_cyc !== 4) begin
      errors++;
      $display("FAIL latency5: %0d cycles, expected 4", done_cyc - acc_cyc);
    end
    checks++;
    if (stock5 !== 8'd19) begin
      errors++;
      $display("FAIL latency5_stock: stock5=%0d, expected 19", stock5);
    end
  endtask
  task automatic test_double10();
    do_reset();
    exp_q.push_back(DENOM_10);
    exp_q.push_back(DENOM_10);
    exp_q.push_back(EV_DONE);
    send(CHG_10_10);
    serve(1, 0);
    checks++;
    if (fire_cyc.size() !== 2) begin
      errors++;
      $display("FAIL double10_fires: %0d fires, expected 2", fire_cyc.size());
    end else begin
      checks++;
      if (fire_cyc[1] - fire_cyc[0] !== 6) begin
        errors++;
        $display("FAIL double10_spacing: %0d cycles, expected 6", fire_cyc[1] - fire_cyc[0]);
      end
    end
    checks++;
    if (stock10 !== 8'd18) begin
      errors++;
      $display("FAIL double10_stock: stock10=%0d, expected 18", stock10);
    end
  endtask
  task automatic test_mixed();
    do_reset();
    exp_q.push_back(DENOM_10);
    exp_q.push_back(DENOM_5);
    exp_q.push_back(EV_DONE);
    send(CHG_5_10);
    serve(1, 0);
    checks++;
    if (stock10 !== 8'd19 || stock5 !== 8'd19) begin
      errors++;
      $display("FAIL mixed_stock: stock10=%0d stock5=%0d, expected 19 19", stock10, stock5);
    end
  endtask
  task automatic test_none();
    do_reset();
    send(CHG_NONE);
    repeat (4) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.change_ready !== 1'b1 || stock5 !== 8'd20 || stock10 !== 8'd20) begin
      errors++;
      $display("FAIL none: busy=%b ready=%b stock5=%0d stock10=%0d, expected 0 1 20 20",
               bus.busy, bus.change_ready, stock5, stock10);
    end
  endtask
  task automatic test_fault();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(DENOM_5);
      exp_q.push_back(EV_DONE);
      send(CHG_5);
      serve(1, 0);
    end
    checks++;
    if (stock5 !== 8'd0) begin
      errors++;
      $display("FAIL drain_stock: stock5=%0d, expected 0", stock5);
    end
    exp_q.push_back(EV_FAULT);
    send(CHG_5);
    serve(1, 0);
    checks++;
    if (stock5 !== 8'd0 || stock10 !== 8'd20 || fire_cyc.size() !== 0) begin
      errors++;
      $display("FAIL empty_fault: stock5=%0d stock10=%0d fires=%0d, expected 0 20 0",
               stock5, stock10, fire_cyc.size());
    end
    exp_q.push_back(EV_FAULT);
    send(3'b110);
    serve(1, 0);
    checks++;
    if (fire_cyc.size() !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_fault: fires=%0d busy=%b, expected 0 0", fire_cyc.size(), bus.busy);
    end
  endtask
  task automatic test_refill();
    do_reset();
    exp_q.push_back(DENOM_10);
    exp_q.push_back(EV_DONE);
    send(CHG_10);
    serve(1, 1);
    checks++;
    if (stock10 !== 8'd24 || stock5 !== 8'd20) begin
      errors++;
      $display("FAIL refill_with_ack: stock10=%0d stock5=%0d, expected 24 20", stock10, stock5);
    end
    do_reset();
    refill10 = 1'b1;
    refill_cnt = 8'd230;
    @(negedge clock);
    refill10 = 1'b0;
    checks++;
    if (stock10 !== 8'd250) begin
      errors++;
      $display("FAIL refill_230: stock10=%0d, expected 250", stock10);
    end
    refill10 = 1'b1;
    refill_cnt = 8'd10;
    @(negedge clock);
    refill10 = 1'b0;
    checks++;
    if (stock10 !== 8'd255) begin
      errors++;
      $display("FAIL refill_saturate10: stock10=%0d, expected 255", stock10);
    end
    refill5 = 1'b1;
    refill_cnt = 8'd255;
    @(negedge clock);
    refill5 = 1'b0;
    checks++;
    if (stock5 !== 8'd255 || stock10 !== 8'd255) begin
      errors++;
      $display("FAIL refill_saturate5: stock5=%0d stock10=%0d, expected 255 255", stock5, stock10);
    end
  endtask
  task automatic test_ignored_ack();
    do_reset();
    @(negedge clock);
    bus.hopper_ack = 1'b1;
    repeat (3) @(negedge clock);
    bus.hopper_ack = 1'b0;
    checks++;
    if (stock5 !== 8'd20 || stock10 !== 8'd20 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack: stock5=%0d stock10=%0d busy=%b, expected 20 20 0",
               stock5, stock10, bus.busy);
    end
  endtask
  task automatic test_reset_mid();
    bit seen = 0;
    do_reset();
    exp_q.push_back(DENOM_10);
    send(CHG_10);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      seen = bus.fire10;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_fire: fire10=0 within 10 cycles, expected 1");
    end
`ifndef CHG_TIMEOUT_EN
    repeat (30) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_forever: busy=%b after 30 cycles, expected 1", bus.busy);
    end
`else
    repeat (3) @(negedge clock);
`endif
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.change_ready !== 1'b1 || stock10 !== 8'd20 || stock5 !== 8'd20) begin
      errors++;
      $display("FAIL reset_mid: busy=%b ready=%b stock10=%0d stock5=%0d, expected 0 1 20 20",
               bus.busy, bus.change_ready, stock10, stock5);
    end
    repeat (10) @(negedge clock);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: done=%b busy=%b, expected 0 0", bus.done, bus.busy);
    end
  endtask
`ifdef CHG_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    exp_q.push_back(DENOM_10);
    exp_q.push_back(EV_FAULT);
    send(CHG_10);
    serve(0, 0);
    checks++;
    if (fire_cyc.size() !== 1 || done_cyc - fire_cyc[0] !== 17) begin
      errors++;
      $display("FAIL timeout_timing: fires=%0d fault %0d cycles after fire, expected 1 17",
               fire_cyc.size(), fire_cyc.size() > 0 ? done_cyc - fire_cyc[0] : -1);
    end
    checks++;
    if (stock10 !== 8'd20 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_stock: stock10=%0d busy=%b, expected 20 0", stock10, bus.busy);
    end
  endtask
`endif
  initial begin
    bus.change = CHG_NONE;
    bus.change_valid = 1'b0;
    bus.hopper_ack = 1'b0;
    test_reset();
    test_single10();
    test_latency5();
    test_double10();
    test_mixed();
    test_none();
    test_fault();
    test_refill();
    test_ignored_ack();
    test_reset_mid();
`ifdef CHG_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d events still expected, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
